// File: rtl/timepulse_gen.sv
// Master timing generator: prescaled sub-phases, one-hot time pulses, RT/WT/CT/EOT strobes,
// overflow sampling and run / stop-at-end / instruction-step / phase-step control.
module timepulse_gen #(
    parameter int NPULSE = 12,
    parameter int PHASES = 4,
    parameter int DIV    = 2,
    parameter int OVF_T  = 10,
    parameter int CNTW   = 16
) (
    input  logic                       CLOCK,
    input  logic                       SIM_RST,
    input  logic                       GOJAM,
    input  logic [1:0]                 MODE,
    input  logic                       STEP,
    input  logic                       WL15,
    input  logic                       WL16,
    output logic [NPULSE-1:0]          T,
    output logic [$clog2(NPULSE)-1:0]  TIDX,
    output logic [PHASES-1:0]          PHS,
    output logic                       RT,
    output logic                       WT,
    output logic                       CT,
    output logic                       EOT,
    output logic                       STOP,
    output logic                       OVF,
    output logic                       UNF,
    output logic [CNTW-1:0]            MCTCNT
);

    localparam int TW = $clog2(NPULSE);
    localparam int PW = $clog2(PHASES);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [PW-1:0] p, p_nxt;
    logic [TW-1:0] t, t_nxt;
    logic          restart;
    logic          armed;
    logic          last_phase, last_pulse, tick, mct_end, hold, ovf_slot;
    logic          step_rel, release_now;

    assign last_phase = (p == PW'(PHASES - 1));
    assign last_pulse = (t == TW'(NPULSE - 1));
    assign tick       = (cnt == CW'(DIV - 1)) && !STOP;
    assign mct_end    = tick && last_phase && last_pulse && !restart;
    assign ovf_slot   = tick && last_phase && (t == TW'(OVF_T - 1));

    // The restart tick always advances so T01 is reached regardless of MODE.
    assign hold = tick && !restart &&
                  ((MODE == 2'b11) ||
                   (((MODE == 2'b01) || (MODE == 2'b10)) && last_phase && last_pulse));

    assign step_rel    = STOP && MODE[1] && STEP && armed;
    assign release_now = STOP && ((MODE == 2'b00) || step_rel);

    assign p_nxt = last_phase ? '0 : p + PW'(1);
    assign t_nxt = !last_phase ? t : (last_pulse ? '0 : t + TW'(1));

    assign T    = NPULSE'(1) << t;
    assign PHS  = PHASES'(1) << p;
    assign TIDX = t;

    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST) begin
            cnt     <= '0;
            p       <= PW'(PHASES - 1);
            t       <= TW'(NPULSE - 1);
            restart <= 1'b1;
            STOP    <= 1'b0;
            RT      <= 1'b0;
            WT      <= 1'b0;
            CT      <= 1'b0;
            EOT     <= 1'b0;
            OVF     <= 1'b0;
            UNF     <= 1'b0;
            MCTCNT  <= '0;
        end else if (GOJAM) begin
            cnt     <= '0;
            p       <= PW'(PHASES - 1);
            t       <= TW'(NPULSE - 1);
            restart <= 1'b1;
            STOP    <= 1'b0;
            RT      <= 1'b0;
            WT      <= 1'b0;
            CT      <= 1'b0;
            EOT     <= 1'b0;
            OVF     <= 1'b0;
            UNF     <= 1'b0;
        end else begin
            RT  <= tick && (p == '0);
            WT  <= tick && (p == PW'(1));
            CT  <= tick && last_phase;
            EOT <= mct_end;
            OVF <= ovf_slot && WL15 && !WL16;
            UNF <= ovf_slot && !WL15 && WL16;
            if (mct_end)
                MCTCNT <= MCTCNT + CNTW'(1);

            if (release_now) begin
                p    <= p_nxt;
                t    <= t_nxt;
                cnt  <= '0;
                STOP <= 1'b0;
            end else if (STOP) begin
                cnt <= '0;
            end else if (tick) begin
                cnt     <= '0;
                restart <= 1'b0;
                if (hold) begin
                    STOP <= 1'b1;
                end else begin
                    p <= p_nxt;
                    t <= t_nxt;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // A held STEP may release only once; it must drop for a clock to re-arm.
    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST)
            armed <= 1'b0;
        else if (!STEP)
            armed <= 1'b1;
        else if (step_rel && !GOJAM)
            armed <= 1'b0;
    end

endmodule

// File: tb/tb_timepulse_gen.sv
// Bench for timepulse_gen: table-driven runs, directed mode/GOJAM sequences and randomized
// stimulus, all compared every clock against a position-based reference model.
module tb_timepulse_gen;

    localparam int NP = 12, PH = 4, DV = 2, OT = 10, CW = 16, NT = NP * PH;

    logic          CLOCK = 1'b0, SIM_RST = 1'b0, GOJAM = 1'b0, STEP = 1'b0;
    logic          WL15 = 1'b0, WL16 = 1'b0;
    logic [1:0]    MODE = 2'b00;
    logic [NP-1:0] T;
    logic [3:0]    TIDX;
    logic [PH-1:0] PHS;
    logic          RT, WT, CT, EOT, STOP, OVF, UNF;
    logic [CW-1:0] MCTCNT;

    timepulse_gen #(.NPULSE(NP), .PHASES(PH), .DIV(DV), .OVF_T(OT), .CNTW(CW)) dut (
        .CLOCK(CLOCK), .SIM_RST(SIM_RST), .GOJAM(GOJAM), .MODE(MODE), .STEP(STEP),
        .WL15(WL15), .WL16(WL16), .T(T), .TIDX(TIDX), .PHS(PHS), .RT(RT), .WT(WT),
        .CT(CT), .EOT(EOT), .STOP(STOP), .OVF(OVF), .UNF(UNF), .MCTCNT(MCTCNT)
    );

    always #5 CLOCK = ~CLOCK;

    int tests = 0, fails = 0;

    // Reference model: position within the MCT (0..NT-1), clocks left in the current phase.
    int m_pos, m_left, m_mct;
    bit m_restart, m_stop, m_armed, m_rt, m_wt, m_ct, m_eot, m_ovf, m_unf;

    function automatic void model_reset();
        m_pos = NT - 1; m_left = DV; m_restart = 1; m_stop = 0; m_armed = 0; m_mct = 0;
        {m_rt, m_wt, m_ct, m_eot, m_ovf, m_unf} = '0;
    endfunction

    function automatic void model_step();
        bit srel;
        int ended, ph;
        {m_rt, m_wt, m_ct, m_eot, m_ovf, m_unf} = '0;
        srel = m_stop && MODE[1] && STEP && m_armed;
        if (GOJAM) begin
            m_pos = NT - 1; m_left = DV; m_restart = 1; m_stop = 0;
        end else if (m_stop) begin
            if (MODE == 2'b00 || srel) begin
                m_pos = (m_pos + 1) % NT; m_stop = 0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                ended = m_pos; ph = ended % PH; m_left = DV;
                m_rt = (ph == 0); m_wt = (ph == 1); m_ct = (ph == PH - 1);
                m_eot = (ended == NT - 1) && !m_restart;
                if (m_ct && ended / PH == OT - 1) begin
                    m_ovf = WL15 && !WL16; m_unf = !WL15 && WL16;
                end
                if (m_eot) m_mct = (m_mct + 1) % (1 << CW);
                if (!m_restart && (MODE == 2'b11 ||
                    ((MODE == 2'b01 || MODE == 2'b10) && ended == NT - 1)))
                    m_stop = 1;
                else
                    m_pos = (m_pos + 1) % NT;
                m_restart = 0;
            end
        end
        if (!STEP) m_armed = 1;
        else if (srel && !GOJAM) m_armed = 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [NP-1:0] te;
        logic [PH-1:0] pe;
        te = '0; te[m_pos / PH] = 1'b1;
        pe = '0; pe[m_pos % PH] = 1'b1;
        check("model", {T, TIDX, PHS, RT, WT, CT, EOT, STOP, OVF, UNF, MCTCNT},
              {te, 4'(m_pos / PH), pe, m_rt, m_wt, m_ct, m_eot, m_stop, m_ovf, m_unf, 16'(m_mct)});
    endtask

    task automatic clk();
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        SIM_RST = 1; GOJAM = 0; STEP = 0; MODE = 2'b00; WL15 = 0; WL16 = 0;
        model_reset();
        repeat (2) @(negedge CLOCK);
        check("reset", {T, TIDX, PHS, RT, WT, CT, EOT, STOP, OVF, UNF, MCTCNT},
              {12'h800, 4'd11, 4'h8, 7'b0, 16'h0});
        SIM_RST = 0;
    endtask

    typedef struct {
        logic [1:0] mode;
        bit         wl15, wl16;
        int         first_eot, n_eot, n_ovf, n_unf, n_rt, mct;
        bit         stop;
        int         tidx, phs;
    } vec_t;

    vec_t vec[6];

    initial begin
        int n_eot, n_ovf, n_unf, n_rt, first, cnt, steps_ok;
        logic [CW-1:0] m0;
        logic [PH-1:0] prev;
        bit found;

        vec[0] = '{2'b00, 1, 0, 98, 3, 3, 0, 36, 3, 0, 0, 0};
        vec[1] = '{2'b00, 0, 1, 98, 3, 0, 3, 36, 3, 0, 0, 0};
        vec[2] = '{2'b00, 1, 1, 98, 3, 0, 0, 36, 3, 0, 0, 0};
        vec[3] = '{2'b01, 1, 0, 98, 1, 1, 0, 12, 1, 1, 11, 3};
        vec[4] = '{2'b10, 0, 1, 98, 1, 0, 1, 12, 1, 1, 11, 3};
        vec[5] = '{2'b11, 1, 0, -1, 0, 0, 0, 1, 0, 1, 0, 0};

        // Table: 290 clocks per entry from reset with static inputs.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            MODE = vec[i].mode; WL15 = vec[i].wl15; WL16 = vec[i].wl16;
            n_eot = 0; n_ovf = 0; n_unf = 0; n_rt = 0; first = -1;
            for (int c = 1; c <= 290; c++) begin
                clk();
                if (EOT) begin n_eot++; if (first < 0) first = c; end
                if (OVF) n_ovf++;
                if (UNF) n_unf++;
                if (RT) n_rt++;
                if (c == 2) check("t01_at_clk2", {T, PHS}, {12'h001, 4'h1});
            end
            check("first_eot", first, vec[i].first_eot);
            check("eot_count", n_eot, vec[i].n_eot);
            check("ovf_unf_count", {16'(n_ovf), 16'(n_unf)}, {16'(vec[i].n_ovf), 16'(vec[i].n_unf)});
            check("rt_count", n_rt, vec[i].n_rt);
            check("mctcnt", MCTCNT, vec[i].mct);
            check("end_state", {STOP, TIDX, PHS},
                  {1'(vec[i].stop), 4'(vec[i].tidx), 4'(1 << vec[i].phs)});
        end

        // Stop-at-end: STEP ignored, MODE=00 releases straight into T01 without a second EOT.
        do_reset();
        MODE = 2'b01;
        repeat (98) clk();
        check("m01_stopped", {STOP, T, PHS}, {1'b1, 12'h800, 4'h8});
        STEP = 1;
        repeat (10) clk();
        check("m01_step_ignored", {STOP, T, PHS}, {1'b1, 12'h800, 4'h8});
        STEP = 0; MODE = 2'b00;
        clk();
        check("m01_release", {STOP, EOT, T, PHS, MCTCNT}, {1'b0, 1'b0, 12'h001, 4'h1, 16'd1});

        // Instruction step: three one-clock pulses, then STEP held for 500 clocks.
        do_reset();
        MODE = 2'b10;
        repeat (98) clk();
        n_eot = 0;
        for (int s = 0; s < 3; s++) begin
            STEP = 1; clk(); STEP = 0;
            cnt = 0;
            do begin clk(); cnt++; if (EOT) n_eot++; end while (!STOP && cnt < 200);
            check("istep_stopped", STOP, 1'b1);
        end
        check("istep_eots", n_eot, 3);
        check("istep_mctcnt", MCTCNT, 16'd4);
        STEP = 1; n_eot = 0;
        for (int c = 0; c < 500; c++) begin clk(); if (EOT) n_eot++; end
        STEP = 0;
        check("istep_held_eots", {n_eot, MCTCNT, STOP}, {32'd1, 16'd5, 1'b1});

        // Phase step: each STEP advances PHS by one; 48 steps cover one MCT.
        do_reset();
        MODE = 2'b11;
        repeat (4) clk();
        check("pstep_first_stop", {STOP, T, PHS}, {1'b1, 12'h001, 4'h1});
        n_eot = 0; steps_ok = 0;
        for (int s = 0; s < NT; s++) begin
            prev = PHS;
            STEP = 1; clk(); STEP = 0;
            if (EOT) n_eot++;
            if (PHS == {prev[PH-2:0], prev[PH-1]} && $onehot(T) && $onehot(PHS)) steps_ok++;
            cnt = 0;
            do begin clk(); cnt++; if (EOT) n_eot++; end while (!STOP && cnt < 10);
        end
        check("pstep_advances", steps_ok, NT);
        check("pstep_eots", {n_eot, MCTCNT}, {32'd1, 16'd1});
        check("pstep_end", {STOP, T, PHS}, {1'b1, 12'h001, 4'h1});

        // GOJAM at T05 phase 2 of the second MCT, held 3 clocks.
        do_reset();
        found = 0; cnt = 0;
        while (!found && cnt < 400) begin
            clk(); cnt++;
            found = (MCTCNT == 16'd1) && (TIDX == 4'd4) && (PHS == 4'b0100);
        end
        check("gojam_wait", found, 1'b1);
        m0 = MCTCNT;
        GOJAM = 1;
        for (int c = 0; c < 3; c++) begin
            clk();
            check("gojam_hold", {RT, WT, CT, EOT, OVF, UNF, STOP, T, PHS, MCTCNT},
                  {7'b0, 12'h800, 4'h8, m0});
        end
        GOJAM = 0;
        clk();
        check("gojam_rel1", {EOT, T, PHS}, {1'b0, 12'h800, 4'h8});
        clk();
        check("gojam_rel2", {EOT, T, PHS, MCTCNT}, {1'b0, 12'h001, 4'h1, m0});

        // Randomized stimulus against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) MODE = 2'($urandom_range(0, 3));
            STEP  = ($urandom_range(0, 3) == 0);
            WL15  = 1'($urandom_range(0, 1));
            WL16  = 1'($urandom_range(0, 1));
            GOJAM = ($urandom_range(0, 199) == 0);
            clk();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timepulse_gen.md
Name: timepulse_gen

Overview:
Parametrised master-timing generator that derives sub-phase, time-pulse and memory-cycle (MCT) timing from the CLOCK input. Outputs are one-hot phase and time-pulse vectors, RT/WT/CT strobes, end-of-MCT and overflow/underflow strobes. It adds run, stop-at-MCT-end, instruction-step and phase-step modes and a MCT counter. It sits between the clock source and the sequence, memory and control logic, and is restarted by GOJAM.

Parameters:
NPULSE, 12, time pulses per MCT (2..32)
PHASES, 4, sub-phases per time pulse (4..8)
DIV, 2, CLOCK cycles per sub-phase (1..64)
OVF_T, 10, time pulse (1-based) whose CT strobe samples WL15/WL16 for overflow
CNTW, 16, width of MCT counter

Ports:
CLOCK  in  1  system clock, all state on rising edge
SIM_RST  in  1  asynchronous active-high reset
GOJAM  in  1  synchronous restart, level
MODE  in  2  00 run, 01 stop-at-MCT-end, 10 instruction-step, 11 phase-step
STEP  in  1  step request, level, sampled only while STOP=1
WL15  in  1  write-bus bit 15
WL16  in  1  write-bus bit 16
T  out  NPULSE  one-hot time pulse, bit0 = T01
TIDX  out  clog2(NPULSE)  index of active time pulse, 0-based
PHS  out  PHASES  one-hot sub-phase, bit0 = phase 0
RT  out  1  read strobe, one clock
WT  out  1  write strobe, one clock
CT  out  1  clear strobe, one clock
EOT  out  1  end-of-MCT strobe, one clock
STOP  out  1  generator frozen awaiting STEP or mode change
OVF  out  1  positive overflow strobe, one clock
UNF  out  1  negative overflow strobe, one clock
MCTCNT  out  CNTW  completed MCTs, wraps modulo 2^CNTW

Behaviour:
- State: prescaler cnt (0..DIV-1), phase p (0..PHASES-1), pulse t (0..NPULSE-1), restart flag, STOP, MCTCNT.
- Tick = cnt==DIV-1 and not frozen. On a tick, cnt goes to 0. Otherwise cnt increments.
- On a tick, p advances. At p==PHASES-1, p goes to 0 and t advances, with t==NPULSE-1 wrapping to 0.
- Reset (SIM_RST) and GOJAM high both give: t=NPULSE-1, p=PHASES-1, cnt=0, restart=1, STOP=0. All strobes 0. MCTCNT=0 on SIM_RST only; GOJAM keeps MCTCNT. GOJAM overrides every other input and holds this state while it stays high.
- The first tick after reset or GOJAM release enters T01 phase 0 after exactly DIV clocks. It clears restart, and suppresses EOT and the MCTCNT increment.
- RT, WT and CT are registered and assert the clock after the tick that ends phase 0, phase 1 and phase PHASES-1 respectively, with T/PHS at that point showing the next position.
- EOT and MCTCNT+1 occur on the tick that ends phase PHASES-1 of pulse NPULSE-1, with restart=0. CT and EOT coincide.
- OVF and UNF are registered in the same clock as CT of pulse OVF_T-1 (0-based). OVF = WL15 & ~WL16. UNF = ~WL15 & WL16. They are 0 at all other times.
- Freeze rules, evaluated on the tick that would advance:
  - MODE 01/10: a tick ending pulse NPULSE-1 phase PHASES-1 still produces CT, EOT and the MCTCNT increment, but leaves t=NPULSE-1, p=PHASES-1. It then sets STOP=1.
  - MODE 11: every phase-ending tick produces its strobes, holds p/t and sets STOP=1.
- While STOP=1, cnt holds at 0 and no strobes fire. Release to continue is any of:
  - MODE=00;
  - MODE=01 changing to 10/11 with STEP=1;
  - STEP=1 in MODE 10/11.
- Release takes effect on the next clock, which performs the withheld advance: p/t move, cnt=0, STOP=0, with no repeated strobes.
- After a release in MODE 10 the block runs one full MCT, then stops again. After a release in MODE 11 it runs one phase.
- A held STEP releases at most once per stop. Re-arming requires STEP=0 for at least one clock.
- MODE changes mid-MCT apply at the next evaluated tick.
- Invariants: exactly one bit set in T and in PHS at all times, including during reset. TIDX always equals the index of the set bit in T.

Test Plan:
- Reset, defaults, MODE=00: T01/PHS[0] 2 clocks after SIM_RST release. RT, WT, CT each once per 8 clocks. First EOT at clock 98, then every 96. MCTCNT=3 at clock 290.
- WL15=1, WL16=0 held: OVF pulses once per MCT, coincident with CT while T10 is ending, and UNF stays 0. Swapping the levels gives UNF only; equal levels give neither.
- MODE=01: STOP=1 after the first EOT with T[11], PHS[3] held. STEP is ignored. Switching MODE to 00 gives T01 the next clock, without a duplicate EOT.
- MODE=10, STEP pulsed 1 clock ×3: exactly 3 EOTs, MCTCNT=+3, STOP=1 between steps. STEP held high for 500 clocks gives exactly 1 MCT.
- MODE=11: each STEP pulse advances PHS by one position. 48 pulses give one EOT, with one-hotness maintained throughout.
- GOJAM asserted at T05 phase 2 for 3 clocks: strobes stop and T/PHS go to T12/PHS[3]. MCTCNT is unchanged. T01 appears 2 clocks after release with no EOT.
